// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for the hazard scoreboard
package hazard_pkg;

    localparam int RW   = 5;
    localparam int NREG = 32;

    localparam logic [RW-1:0] REG_ZERO = '0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_issue_fsm.sv
// rtl/md_issue_fsm.sv - issue FSM for the single mul/div unit, tracks its destination
module md_issue_fsm #(
    parameter int NREG = hazard_pkg::NREG,
    parameter int RW   = hazard_pkg::RW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            launch,
    input  logic [RW-1:0]   launch_rd,
    input  logic            md_done,
    output logic            md_start,
    output logic            md_busy,
    output logic [NREG-1:0] md_pend
);
    import hazard_pkg::*;

    md_state_t     state;
    md_state_t     state_nxt;
    logic [RW-1:0] md_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            md_rd <= '0;
        end else begin
            state <= state_nxt;
            if (state == MD_IDLE && launch) begin
                md_rd <= launch_rd;
            end
        end
    end

    // md_done while IDLE belongs to an operation abandoned by reset
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (launch)  state_nxt = MD_BUSY;
            MD_BUSY: if (md_done) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        md_start = (state == MD_IDLE) && launch;
        md_busy  = (state == MD_BUSY);
        md_pend  = '0;
        if (state == MD_BUSY && md_rd != REG_ZERO) begin
            md_pend[md_rd] = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard; HAZARD_PERF_EN adds stall counters
module hazard_scoreboard #(
    parameter int NREG = hazard_pkg::NREG,
    parameter int RW   = hazard_pkg::RW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_writeReg,
    input  logic            id_is_load,
    input  logic            id_is_muldiv,
    input  logic            ex_flush,
    input  logic            md_done,
    output logic            id_stall,
    output logic            ex_bubble,
    output logic            md_start,
    output logic            md_busy,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stall_cycles,
    output logic [31:0]     stall_md,
`endif
    output logic [NREG-1:0] pend_vec
);
    import hazard_pkg::*;

    logic [NREG-1:0] load_pend;
    logic [NREG-1:0] md_pend;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            haz_md;
    logic            haz_waw;
    logic            id_fire;
    logic [RW-1:0]   launch_rd;

    assign pend_vec = load_pend | md_pend;

    assign haz_rs1 = id_use_rs1 & (id_rs1 != REG_ZERO) & pend_vec[id_rs1];
    assign haz_rs2 = id_use_rs2 & (id_rs2 != REG_ZERO) & pend_vec[id_rs2];
    assign haz_md  = id_is_muldiv & md_busy;
    assign haz_waw = id_writeReg & (id_rd != REG_ZERO) & pend_vec[id_rd];

    assign id_stall  = id_valid & ~ex_flush & (haz_rs1 | haz_rs2 | haz_md | haz_waw);
    assign id_fire   = id_valid & ~ex_flush & ~id_stall;
    assign ex_bubble = id_stall | ex_flush | (id_fire & id_is_muldiv);
    assign launch_rd = id_writeReg ? id_rd : REG_ZERO;

    // A load is only unforwardable while it sits in EX; from ME on WB forwarding covers it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_pend <= '0;
        end else begin
            load_pend <= '0;
            if (id_fire && id_is_load && id_writeReg && id_rd != REG_ZERO) begin
                load_pend[id_rd] <= 1'b1;
            end
        end
    end

    md_issue_fsm #(
        .NREG (NREG),
        .RW   (RW)
    ) u_md_issue_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (id_fire & id_is_muldiv),
        .launch_rd (launch_rd),
        .md_done   (md_done),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .md_pend   (md_pend)
    );

`ifdef HAZARD_PERF_EN
    logic md_match;

    assign md_match = (id_use_rs1 & (id_rs1 != REG_ZERO) & md_pend[id_rs1])
                    | (id_use_rs2 & (id_rs2 != REG_ZERO) & md_pend[id_rs2])
                    | (id_writeReg & (id_rd != REG_ZERO) & md_pend[id_rd]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            stall_md     <= '0;
        end else begin
            if (id_stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (id_stall && (haz_md || md_match) && stall_md != '1) begin
                stall_md <= stall_md + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side hazard tracker for the 5-stage RV32 pipeline; the issuing counterpart of the EX/ME forwarding logic.
- Records destination registers whose results cannot yet be forwarded:
  - load in EX (data only at WB);
  - outstanding multi-cycle mul/div result.
- Stalls the instruction in ID until every source it reads is forwardable.
- Sits between ID decode and the ID/EX register. Owns the single mul/div unit's issue FSM.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- RW, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1  in  RW  ID source 1 index
- id_rs2  in  RW  ID source 2 index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  RW  ID destination index
- id_writeReg  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_is_muldiv  in  1  instruction is mul/div/rem
- ex_flush  in  1  taken branch/jump resolved in EX; kills ID this cycle
- md_done  in  1  mul/div result valid this cycle, written back via WB
- id_stall  out  1  hold PC and IF/ID register
- ex_bubble  out  1  load NOP into ID/EX
- md_start  out  1  one-cycle launch pulse to mul/div unit
- md_busy  out  1  mul/div FSM in BUSY
- pend_vec  out  NREG  registers currently unforwardable (bit 0 always 0)

Behaviour:
- Reset (rst_n low at posedge):
  - load_pend = 0, md_pend = 0, md_rd = 0, FSM = IDLE.
  - All outputs 0.
  - Reset mid-mul/div abandons the operation; a later md_done while IDLE is ignored.
- Source hazard, per source s in {rs1, rs2}:
  - haz_s = id_use_s & (id_s != 0) & pend_vec[id_s].
- Structural hazard:
  - haz_md = id_is_muldiv & (state == BUSY).
- WAW hazard:
  - haz_waw = id_writeReg & (id_rd != 0) & pend_vec[id_rd].
- Stall and issue (combinational):
  - id_stall = id_valid & ~ex_flush & (haz_rs1 | haz_rs2 | haz_md | haz_waw).
  - id_fire = id_valid & ~ex_flush & ~id_stall.
  - ex_bubble = id_stall | ex_flush | (id_fire & id_is_muldiv); mul/div never enters the ALU path.
- Load tracking:
  - On id_fire & id_is_load & id_writeReg & id_rd != 0: load_pend[id_rd] is set for exactly the next cycle (load in EX), then cleared.
  - EX/ME/WB never stall, so a consumer issues one cycle later and picks the value up via WB forwarding.
  - This gives a 1-cycle load-use penalty.
- Mul/div FSM:
  - IDLE -> BUSY on id_fire & id_is_muldiv:
    - md_start = 1 that cycle;
    - md_rd latched (0 if ~id_writeReg);
    - md_pend[md_rd] set if md_rd != 0.
  - BUSY -> IDLE on md_done: md_pend cleared at that edge. Consumers stalled during the md_done cycle issue the following cycle.
  - Simultaneous md_done and a new mul/div in ID: the new one is still stalled that cycle (haz_md) and issues next cycle.
  - md_done in IDLE: no effect.
  - md_start only in IDLE.
- pend_vec = load_pend | md_pend.
  - At most one bit from each source.
  - Bits may coincide when a load and a mul/div target the same rd; WAW stall prevents that ordering.
- ex_flush:
  - Suppresses id_fire and therefore any scoreboard set.
  - Never clears existing entries: they belong to instructions older than the branch.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds ports stall_cycles out 32 and stall_md out 32.
  - Saturating counters of cycles with id_stall = 1, and with id_stall caused by haz_md or an md_pend match.
  - Both counters zeroed by reset.
- HAZARD_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg:
  - RW/NREG constants;
  - md_state_t enum {MD_IDLE, MD_BUSY};
  - REG_ZERO constant.
- One natural sub-module, md_issue_fsm: FSM, md_rd latch, md_pend register, md_start and md_busy outputs.
- Top level holds load tracking, hazard compare, stall logic and optional counters.

Test Plan:
- Load x5 issued cycle t, next ID instruction reads rs1 = x5 -> id_stall = 1 and ex_bubble = 1 at t+1; issues at t+2; pend_vec[5] = 1 only during t+1.
- Load with rd = x0, consumer reads x0 -> no stall; pend_vec stays 0.
- DIV into x7 issued, md_done asserted 6 cycles later; ADD reading x7 waits in ID -> id_stall held 6 cycles; ADD issues the cycle after md_done; md_start pulses once.
- Second MUL in ID while BUSY, md_done same cycle -> MUL stalled that cycle, issues next with md_start = 1.
- Consumer stalled on x5 while ex_flush = 1 -> id_stall = 0, ex_bubble = 1, no scoreboard change.
- rst_n low while BUSY with md_pend[9] = 1, then md_done -> FSM IDLE, pend_vec = 0, md_done ignored; with HAZARD_PERF_EN, counters read 0 after reset.
